mem_stage: RTL and testbench

Memory-access stage of the five-stage RV32I pipeline, directly downstream of the execute stage. It registers the execute result, performs loads and stores over a request/acknowledge data-memory port, aligns and extends load data, and presents `rd_MEM`/`res_MEM` and `rd_WB`/`res_WB` to the execute stage's forwarding and register-write logic. It stalls the front of the pipeline while a memory access is outstanding.

---
 rtl/riscv_pkg.sv | 80 ++++++++
 rtl/load_align.sv | 35 +++
 rtl/mem_stage.sv | 172 +++++++++++++++++
 tb/tb_mem_stage.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the memory stage: opcodes, load/store width codes,
// the memory-access FSM state type, the EX/MEM register layout, and lane helpers.
// Purely declarative; no latency, no backpressure.
package riscv_pkg;

   // Major opcodes seen by the memory stage.
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] REG_OP = 7'b0110011;
   localparam logic [6:0] IMM_OP = 7'b0010011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] JALR   = 7'b1100111;

   // Load width/sign codes.
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   // Store width codes.
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } mem_state_e;

   // EX/MEM pipeline register contents.
   typedef struct packed {
      logic        valid;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [4:0]  rd;
      logic [31:0] res;
      logic [31:0] sdata;
   } exmem_t;

   // Byte lane where the access starts. Halfwords only look at addr[1] and
   // words always start at lane 0, so unchecked low bits are simply dropped.
   function automatic logic [1:0] lane_offset(input logic [2:0] funct3,
                                              input logic [1:0] addr_lo);
      logic [1:0] off;
      case (funct3[1:0])
         2'b00:   off = addr_lo;
         2'b01:   off = {addr_lo[1], 1'b0};
         default: off = 2'b00;
      endcase
      return off;
   endfunction

   // Byte enables for an access starting at lane 'off' (already width-aligned).
   function automatic logic [3:0] byte_enables(input logic [2:0] funct3,
                                               input logic [1:0] off);
      logic [3:0] be;
      case (funct3[1:0])
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = 4'b0011 << off;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Replicate store data across all lanes so the memory can pick any lane
   // using the byte enables alone.
   function automatic logic [31:0] store_lanes(input logic [2:0]  funct3,
                                               input logic [31:0] data);
      logic [31:0] w;
      case (funct3[1:0])
         2'b00:   w = {4{data[7:0]}};
         2'b01:   w = {2{data[15:0]}};
         default: w = data;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/load_align.sv
// Load data aligner: shifts the read word down to the addressed lane and extends it.
// Purely combinational, zero latency.
// No flow control; output follows the inputs.
//
// Ports:
//   rdata_i  - raw 32-bit word from data memory
//   offset_i - starting byte lane of the access
//   funct3_i - load width/sign code (LB, LH, LW, LBU, LHU)
//   data_o   - aligned, sign/zero-extended result
module load_align
   import riscv_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  offset_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [31:0] shifted;

   assign shifted = rdata_i >> {offset_i, 3'b000};

   always_comb begin
      data_o = shifted;
      case (funct3_i)
         LB:      data_o = {{24{shifted[7]}},  shifted[7:0]};
         LH:      data_o = {{16{shifted[15]}}, shifted[15:0]};
         LW:      data_o = shifted;
         LBU:     data_o = {24'h000000, shifted[7:0]};
         LHU:     data_o = {16'h0000,   shifted[15:0]};
         default: data_o = shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: EX/MEM register, data-memory req/ack access, load alignment, MEM/WB register.
// Latency: non-memory op reaches WB 1 cycle after entering MEM; memory op on the edge after dmem_ack.
// Backpressure: stall_MEM holds the upstream stages and the EX/MEM register until the access is acked.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN (adds misalign_MEM; misaligned H/W accesses issue no request).
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   *_EX                - instruction arriving from execute (valid, opcode, funct3, rd, result/address, store data)
//   stall_MEM           - freezes fetch/decode/execute
//   dmem_*              - request/acknowledge data-memory port (word address, byte enables, replicated data)
//   rd_MEM / res_MEM    - forwarding tap from the MEM slot
//   rd_WB / res_WB      - register write-back (rd_WB = 0 means no write)
//   misalign_MEM        - one-cycle misaligned-access flag (only with MEM_ALIGN_CHECK_EN)
module mem_stage
   import riscv_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_EX,
   input  logic [6:0]        opcode_EX,
   input  logic [2:0]        funct3_EX,
   input  logic [4:0]        rd_EX,
   input  logic [31:0]       res_EX,
   input  logic [31:0]       x2_EX,
   output logic              stall_MEM,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [3:0]        dmem_be,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_ack,
   input  logic [31:0]       dmem_rdata,
   output logic [4:0]        rd_MEM,
   output logic [31:0]       res_MEM,
   output logic [4:0]        rd_WB,
   output logic [31:0]       res_WB
`ifdef MEM_ALIGN_CHECK_EN
   ,
   output logic              misalign_MEM
`endif
);

   exmem_t     ex_q, ex_d;
   mem_state_e state_q, state_d;
   logic [4:0]  rd_wb_q, rd_wb_d;
   logic [31:0] res_wb_q, res_wb_d;

   logic        is_load;
   logic        is_store;
   logic        is_mem;
   logic        misaligned;
   logic        mem_issue;
   logic        writes_rd;
   logic [1:0]  offset;
   logic [31:0] load_data;

   // ------------------------------------------------------------------
   // MEM slot decode
   // ------------------------------------------------------------------
   assign is_load  = ex_q.valid & (ex_q.opcode == LOAD);
   assign is_store = ex_q.valid & (ex_q.opcode == STORE);
   assign is_mem   = is_load | is_store;

`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned = is_mem &
                       (((ex_q.funct3[1:0] == 2'b01) & ex_q.res[0]) |
                        ((ex_q.funct3[1:0] == 2'b10) & (ex_q.res[1:0] != 2'b00)));
   assign misalign_MEM = misaligned;
`else
   assign misaligned = 1'b0;
`endif

   // A misaligned access never reaches the memory port, so it cannot stall.
   assign mem_issue = is_mem & ~misaligned;
   assign writes_rd = (ex_q.opcode != STORE) & (ex_q.opcode != BRANCH);
   assign offset    = lane_offset(ex_q.funct3, ex_q.res[1:0]);

   load_align u_load_align (
      .rdata_i  (dmem_rdata),
      .offset_i (offset),
      .funct3_i (ex_q.funct3),
      .data_o   (load_data)
   );

   // An ack without an issued access (req low) has no effect here.
   assign stall_MEM = mem_issue & ~dmem_ack;

   // ------------------------------------------------------------------
   // Access FSM. The request is raised combinationally from IDLE so a
   // zero-wait memory completes in the instruction's first MEM cycle.
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      dmem_req = 1'b0;
      case (state_q)
         IDLE: begin
            dmem_req = mem_issue;
            if (mem_issue & ~dmem_ack) begin
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            dmem_req = 1'b1;
            if (dmem_ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Port fields are driven from the held EX/MEM register, so they stay
   // stable for the whole access; zero when nothing is issued.
   assign dmem_we    = mem_issue & is_store;
   assign dmem_addr  = mem_issue ? {ex_q.res[ADDR_W-1:2], 2'b00} : '0;
   assign dmem_be    = mem_issue ? byte_enables(ex_q.funct3, offset) : 4'b0000;
   assign dmem_wdata = (mem_issue & is_store) ? store_lanes(ex_q.funct3, ex_q.sdata) : 32'h0;

   // ------------------------------------------------------------------
   // Forwarding taps
   // ------------------------------------------------------------------
   assign rd_MEM  = (ex_q.valid & writes_rd & ~misaligned) ? ex_q.rd : 5'd0;
   // Load data is only meaningful in the ack cycle; in any other cycle the
   // stall keeps consumers from using it.
   assign res_MEM = is_load ? load_data : ex_q.res;

   // ------------------------------------------------------------------
   // Next-state for the pipeline registers
   // ------------------------------------------------------------------
   always_comb begin
      ex_d = ex_q;
      if (!stall_MEM) begin
         ex_d.valid  = valid_EX;
         ex_d.opcode = opcode_EX;
         ex_d.funct3 = funct3_EX;
         ex_d.rd     = rd_EX;
         ex_d.res    = res_EX;
         ex_d.sdata  = x2_EX;
      end
   end

   // A stalled edge pushes a bubble into WB.
   always_comb begin
      rd_wb_d  = rd_MEM;
      res_wb_d = res_MEM;
      if (stall_MEM) begin
         rd_wb_d  = 5'd0;
         res_wb_d = res_wb_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q     <= '0;
         state_q  <= IDLE;
         rd_wb_q  <= 5'd0;
         res_wb_q <= 32'h0;
      end else begin
         ex_q     <= ex_d;
         state_q  <= state_d;
         rd_wb_q  <= rd_wb_d;
         res_wb_q <= res_wb_d;
      end
   end

   assign rd_WB  = rd_wb_q;
   assign res_WB = res_wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: the bench plays the data memory and keeps a
// transaction-level model of the MEM slot, the WB result and memory contents.
module tb_mem_stage;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_EX;
   logic [6:0]  opcode_EX;
   logic [2:0]  funct3_EX;
   logic [4:0]  rd_EX;
   logic [31:0] res_EX;
   logic [31:0] x2_EX;
   logic        stall_MEM;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic [4:0]  rd_MEM;
   logic [31:0] res_MEM;
   logic [4:0]  rd_WB;
   logic [31:0] res_WB;
`ifdef MEM_ALIGN_CHECK_EN
   logic        misalign_MEM;
`endif

   always #5 clk = ~clk;

   mem_stage #(.ADDR_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .valid_EX   (valid_EX),
      .opcode_EX  (opcode_EX),
      .funct3_EX  (funct3_EX),
      .rd_EX      (rd_EX),
      .res_EX     (res_EX),
      .x2_EX      (x2_EX),
      .stall_MEM  (stall_MEM),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_be    (dmem_be),
      .dmem_wdata (dmem_wdata),
      .dmem_ack   (dmem_ack),
      .dmem_rdata (dmem_rdata),
      .rd_MEM     (rd_MEM),
      .res_MEM    (res_MEM),
      .rd_WB      (rd_WB),
      .res_WB     (res_WB)
`ifdef MEM_ALIGN_CHECK_EN
      ,
      .misalign_MEM (misalign_MEM)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic        valid;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] res;
      logic [31:0] x2;
   } instr_t;

   instr_t      slot;
   logic [31:0] mem [16];
   logic [4:0]  wb_rd;
   logic [31:0] wb_res;
   bit          wb_known;
   bit          busy;
   int          wait_left;

   logic [2:0]  lf3 [5];
   logic [6:0]  oth [5];

   bit          exp_req, ack, exp_stall, res_known;
   logic [4:0]  exp_rd_mem;
   logic [31:0] exp_res_mem;

   function automatic int nbytes(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   // First lane touched: bytes use the full offset, halfwords only bit 1.
   function automatic int start_lane(input logic [2:0] f3, input logic [31:0] a);
      if (f3[1:0] == 2'b00) return int'(a[1:0]);
      if (f3[1:0] == 2'b01) return a[1] ? 2 : 0;
      return 0;
   endfunction

   function automatic bit is_mem_op(input instr_t i);
      return i.valid && (i.op == LOAD || i.op == STORE);
   endfunction

   function automatic bit misal(input instr_t i);
`ifdef MEM_ALIGN_CHECK_EN
      return is_mem_op(i) && ((nbytes(i.f3) == 2 && i.res[0]) ||
                              (nbytes(i.f3) == 4 && i.res[1:0] != 2'b00));
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [3:0] model_be(input instr_t i);
      logic [3:0] be;
      int s, n;
      s = start_lane(i.f3, i.res);
      n = nbytes(i.f3);
      for (int b = 0; b < 4; b++) be[b] = (b >= s) && (b < s + n);
      return be;
   endfunction

   function automatic logic [31:0] model_wdata(input instr_t i);
      logic [31:0] w;
      int n;
      n = nbytes(i.f3);
      for (int b = 0; b < 4; b++) w[8*b +: 8] = i.x2[8*(b % n) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] model_load(input instr_t i, input logic [31:0] word);
      logic [31:0] v;
      int s, n;
      s = start_lane(i.f3, i.res);
      n = nbytes(i.f3);
      v = 32'h0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = word[8*(s+k) +: 8];
      if (!i.f3[2] && n < 4 && v[8*n-1])
         for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
      return v;
   endfunction

   task automatic drive_ex();
      int sel;
      sel       = $urandom_range(0, 9);
      valid_EX  = ($urandom_range(0, 7) != 0);
      rd_EX     = 5'($urandom);
      x2_EX     = $urandom;
      funct3_EX = 3'($urandom);
      res_EX    = $urandom;
      if (sel <= 2) begin
         opcode_EX = LOAD;
         funct3_EX = lf3[$urandom_range(0, 4)];
         res_EX    = 32'h100 + $urandom_range(0, 63);
      end else if (sel <= 4) begin
         opcode_EX = STORE;
         funct3_EX = 3'($urandom_range(0, 2));
         res_EX    = 32'h100 + $urandom_range(0, 63);
      end else begin
         opcode_EX = oth[$urandom_range(0, 4)];
      end
   endtask

   initial begin
      lf3 = '{LB, LH, LW, LBU, LHU};
      oth = '{BRANCH, REG_OP, IMM_OP, LUI, JALR};
      for (int i = 0; i < 16; i++) mem[i] = $urandom;

      reset = 1'b1; valid_EX = 1'b0; opcode_EX = LOAD; funct3_EX = LW;
      rd_EX = 5'd3; res_EX = 32'h104; x2_EX = 32'h0;
      dmem_ack = 1'b0; dmem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      // Even with a load on the EX inputs, reset keeps everything quiet.
      check_eq("rst_stall", 32'(stall_MEM), 32'h0);
      check_eq("rst_req",   32'(dmem_req),  32'h0);
      check_eq("rst_we",    32'(dmem_we),   32'h0);
      check_eq("rst_be",    32'(dmem_be),   32'h0);
      check_eq("rst_addr",  dmem_addr,      32'h0);
      check_eq("rst_wdata", dmem_wdata,     32'h0);
      check_eq("rst_rdmem", 32'(rd_MEM),    32'h0);
      check_eq("rst_resmem", res_MEM,       32'h0);
      check_eq("rst_rdwb",  32'(rd_WB),     32'h0);
      check_eq("rst_reswb", res_WB,         32'h0);

      reset = 1'b0;
      slot.valid = 1'b0; slot.op = 7'h0; slot.f3 = 3'h0; slot.rd = 5'h0;
      slot.res = 32'h0; slot.x2 = 32'h0;
      wb_rd = 5'd0; wb_res = 32'h0; wb_known = 1'b1;
      busy = 1'b0; wait_left = 0;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         drive_ex();
         // Memory side: respond to what the model says should be requested.
         exp_req = is_mem_op(slot) && !misal(slot);
         if (exp_req) begin
            if (!busy) begin
               busy      = 1'b1;
               wait_left = $urandom_range(0, 2);
            end
            ack = (wait_left == 0);
         end else begin
            ack = ($urandom_range(0, 3) == 0);   // stray acks must be ignored
         end
         dmem_ack   = ack;
         dmem_rdata = (exp_req && ack) ? mem[slot.res[5:2]] : $urandom;
         #1;

         exp_stall  = exp_req && !ack;
         exp_rd_mem = (slot.valid && slot.op != STORE && slot.op != BRANCH && !misal(slot))
                      ? slot.rd : 5'd0;
         res_known  = 1'b0;
         exp_res_mem = 32'h0;
         if (slot.valid && !is_mem_op(slot)) begin
            res_known   = 1'b1;
            exp_res_mem = slot.res;
         end else if (exp_req && ack && slot.op == LOAD) begin
            res_known   = 1'b1;
            exp_res_mem = model_load(slot, mem[slot.res[5:2]]);
         end

         check_eq("stall", 32'(stall_MEM), 32'(exp_stall));
         check_eq("req",   32'(dmem_req),  32'(exp_req));
         if (exp_req) begin
            check_eq("addr", dmem_addr, {slot.res[31:2], 2'b00});
            check_eq("be",   32'(dmem_be), 32'(model_be(slot)));
            check_eq("we",   32'(dmem_we), 32'(slot.op == STORE));
            if (slot.op == STORE) check_eq("wdata", dmem_wdata, model_wdata(slot));
         end
         check_eq("rd_MEM", 32'(rd_MEM), 32'(exp_rd_mem));
         if (res_known) check_eq("res_MEM", res_MEM, exp_res_mem);
         check_eq("rd_WB", 32'(rd_WB), 32'(wb_rd));
         if (wb_known) check_eq("res_WB", res_WB, wb_res);
`ifdef MEM_ALIGN_CHECK_EN
         check_eq("misalign", 32'(misalign_MEM), 32'(misal(slot)));
`endif

         // Model update for the coming edge.
         if (exp_stall) begin
            wb_rd     = 5'd0;
            wb_known  = 1'b0;
            wait_left = wait_left - 1;
         end else begin
            wb_rd    = exp_rd_mem;
            wb_res   = exp_res_mem;
            wb_known = res_known;
            if (exp_req) begin
               busy = 1'b0;
               if (slot.op == STORE) begin
                  for (int k = 0; k < nbytes(slot.f3); k++)
                     mem[slot.res[5:2]][8*(start_lane(slot.f3, slot.res)+k) +: 8] = slot.x2[8*k +: 8];
               end
            end
            slot.valid = valid_EX; slot.op = opcode_EX; slot.f3 = funct3_EX;
            slot.rd = rd_EX; slot.res = res_EX; slot.x2 = x2_EX;
         end
         @(posedge clk);
         #1;
      end

      // Reset in the middle of an outstanding load.
      dmem_ack = 1'b0; reset = 1'b1; valid_EX = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      valid_EX = 1'b1; opcode_EX = LOAD; funct3_EX = LW; rd_EX = 5'd7; res_EX = 32'h140;
      @(posedge clk); #1;
      check_eq("mid_req",   32'(dmem_req),  32'h1);
      check_eq("mid_addr",  dmem_addr,      32'h140);
      check_eq("mid_stall", 32'(stall_MEM), 32'h1);
      reset = 1'b1; valid_EX = 1'b0;
      @(posedge clk); #1;
      check_eq("abort_req",  32'(dmem_req), 32'h0);
      check_eq("abort_rdwb", 32'(rd_WB),    32'h0);
      check_eq("abort_rdmem", 32'(rd_MEM),  32'h0);
      reset = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
      #1;
      check_eq("lost_ack_stall", 32'(stall_MEM), 32'h0);
      check_eq("lost_ack_req",   32'(dmem_req),  32'h0);
      @(posedge clk); #1;
      check_eq("lost_ack_rdwb", 32'(rd_WB), 32'h0);
      dmem_ack = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
